// File: rtl/vliw_pkg.sv
// Shared constants for the VLIW fetch path: bundle layout, ALU opcodes and
// fetch FSM state encoding.
package vliw_pkg;

  localparam int BUNDLE_W     = 32;

  localparam int SLOT0_OP_MSB = 31;
  localparam int SLOT0_OP_LSB = 24;
  localparam int SLOT1_OP_MSB = 23;
  localparam int SLOT1_OP_LSB = 16;
  localparam int DEST0_MSB    = 15;
  localparam int DEST0_LSB    = 12;
  localparam int DEST1_MSB    = 11;
  localparam int DEST1_LSB    = 8;

  localparam logic [7:0] OP_ADD = 8'h00;
  localparam logic [7:0] OP_SUB = 8'h01;
  localparam logic [7:0] OP_AND = 8'h02;
  localparam logic [7:0] OP_OR  = 8'h03;
  localparam logic [7:0] OP_XOR = 8'h04;
  localparam logic [7:0] OP_NOT = 8'h05;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_DISCARD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/vliw_fifo.sv
// Synchronous first-word-fall-through FIFO with flush; storage is not reset,
// consumers must qualify pop_data with valid.
module vliw_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic [DATA_W-1:0]          push_data,
  input  logic                       pop,
  output logic [DATA_W-1:0]          pop_data,
  output logic                       valid,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] level
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic              do_push, do_pop;

  assign valid    = (level != '0);
  assign full     = (level == LW'(DEPTH));
  assign pop_data = mem[rd_ptr];

  // Flush dominates; a push into a full FIFO is only taken alongside a pop.
  assign do_pop  = pop && valid && !flush;
  assign do_push = push && !flush && (!full || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      level <= level + LW'(do_push) - LW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/vliw_fetch_queue.sv
// VLIW instruction fetch FSM feeding a bundle FIFO, with branch redirect.
// Optional stall counter output enabled by macro VLIW_FETCH_STALL_CNT_EN.
module vliw_fetch_queue
  import vliw_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       imem_req,
  output logic [AW-1:0]              imem_addr,
  input  logic                       imem_ack,
  input  logic [BUNDLE_W-1:0]        imem_data,
  output logic                       issue_valid,
  output logic [BUNDLE_W-1:0]        issue_bundle,
  output logic [AW-1:0]              issue_pc,
  input  logic                       issue_ready,
  input  logic                       redirect_valid,
  input  logic [AW-1:0]              redirect_pc,
  output logic [$clog2(DEPTH+1)-1:0] fifo_level
`ifdef VLIW_FETCH_STALL_CNT_EN
  ,
  output logic [15:0]                stall_count
`endif
);
  localparam logic [1:0] IDLE    = ST_IDLE;
  localparam logic [1:0] FETCH   = ST_FETCH;
  localparam logic [1:0] DISCARD = ST_DISCARD;
  localparam int         QW      = BUNDLE_W + AW;

  logic [1:0]    state, state_nxt;
  logic [AW-1:0] pc, req_addr;
  logic          xfer, push, pop, full, head_vld;
  logic [QW-1:0] head;

  assign imem_req  = (state == FETCH) || (state == DISCARD);
  assign imem_addr = req_addr;
  assign xfer      = imem_req && imem_ack;
  assign push      = (state == FETCH) && xfer && !redirect_valid;
  assign pop       = head_vld && issue_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      // A redirect empties the FIFO, so it always leaves room for a fetch.
      IDLE:    if (redirect_valid || !full || pop) state_nxt = FETCH;
      FETCH:   if (xfer) state_nxt = IDLE;
               else if (redirect_valid) state_nxt = DISCARD;
      DISCARD: if (xfer) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      pc       <= '0;
      req_addr <= '0;
    end else begin
      state <= state_nxt;
      if (redirect_valid)  pc <= redirect_pc;
      else if (push)       pc <= pc + AW'(1);
      // The request address is frozen for the life of a request, including DISCARD.
      if (state == IDLE && state_nxt == FETCH)
        req_addr <= redirect_valid ? redirect_pc : pc;
    end
  end

  vliw_fifo #(
    .DATA_W (QW),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (push),
    .push_data ({imem_data, req_addr}),
    .pop       (pop),
    .pop_data  (head),
    .valid     (head_vld),
    .full      (full),
    .level     (fifo_level)
  );

  assign issue_valid  = head_vld;
  assign issue_bundle = head_vld ? head[QW-1:AW] : '0;
  assign issue_pc     = head_vld ? head[AW-1:0]  : '0;

`ifdef VLIW_FETCH_STALL_CNT_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              stall_count <= '0;
    else if (issue_valid && !issue_ready) stall_count <= sat_inc(stall_count);
  end
`endif

endmodule

// File: tb/tb_vliw_fetch_queue.sv
// Self-checking bench for vliw_fetch_queue: table-driven fill sequence, a
// bundle scoreboard, and hand-written redirect/reset corner cases.
module tb_vliw_fetch_queue;
  localparam int DEPTH = 4;
  localparam int AW    = 8;
  localparam int LW    = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          rst;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack;
  logic [31:0]   imem_data;
  logic          issue_valid;
  logic [31:0]   issue_bundle;
  logic [AW-1:0] issue_pc;
  logic          issue_ready;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic [LW-1:0] fifo_level;
`ifdef VLIW_FETCH_STALL_CNT_EN
  logic [15:0]   stall_count;
`endif

  always #5 clk = ~clk;

  assign imem_data = 32'h0001_2300 + {24'h0, imem_addr};

  vliw_fetch_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_data      (imem_data),
    .issue_valid    (issue_valid),
    .issue_bundle   (issue_bundle),
    .issue_pc       (issue_pc),
    .issue_ready    (issue_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fifo_level     (fifo_level)
`ifdef VLIW_FETCH_STALL_CNT_EN
    ,
    .stall_count    (stall_count)
`endif
  );

  typedef struct packed {
    logic [31:0]   bundle;
    logic [AW-1:0] pc;
  } entry_t;

  typedef struct {
    logic          ack;
    logic          ready;
    logic          req;
    logic [AW-1:0] addr;
    logic [LW-1:0] level;
  } vec_t;

  int            n_checks = 0;
  int            n_fail   = 0;
  entry_t        sb[$];
  logic [AW-1:0] exp_fetch, exp_issue, held_addr, last_pop;
  logic          discard_pend, held, have_last, saw_wrap;
  vec_t          tbl[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called at a falling edge with inputs settled: check outputs, predict the
  // next rising edge, then advance one cycle.
  task automatic step();
    if (held) begin
      check("req_held", 64'(imem_req), 64'(1));
      check("addr_stable", 64'(imem_addr), 64'(held_addr));
    end
    check("level", 64'(fifo_level), 64'(sb.size()));
    check("issue_valid", 64'(issue_valid), 64'(sb.size() != 0));
    if (sb.size() != 0) begin
      check("issue_pc", 64'(issue_pc), 64'(sb[0].pc));
      check("issue_bundle", 64'(issue_bundle), 64'(sb[0].bundle));
    end
    held      = imem_req && !imem_ack;
    held_addr = imem_addr;
    if (redirect_valid) begin
      discard_pend = imem_req && !imem_ack;
      sb.delete();
      exp_fetch = redirect_pc;
      exp_issue = redirect_pc;
    end else begin
      if (issue_valid && issue_ready) begin
        check("pop_pc_seq", 64'(issue_pc), 64'(exp_issue));
        if (have_last && last_pop == 8'hFF && issue_pc == 8'h00) saw_wrap = 1'b1;
        last_pop  = issue_pc;
        have_last = 1'b1;
        exp_issue = exp_issue + 8'd1;
        if (sb.size() != 0) void'(sb.pop_front());
      end
      if (imem_req && imem_ack) begin
        if (discard_pend) discard_pend = 1'b0;
        else begin
          check("fetch_addr", 64'(imem_addr), 64'(exp_fetch));
          exp_fetch = exp_fetch + 8'd1;
          sb.push_back('{bundle: imem_data, pc: imem_addr});
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; imem_ack = 1'b0; issue_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    repeat (2) @(negedge clk);
    check("rst_req", 64'(imem_req), 64'(0));
    check("rst_valid", 64'(issue_valid), 64'(0));
    check("rst_bundle", 64'(issue_bundle), 64'(0));
    check("rst_pc", 64'(issue_pc), 64'(0));
    check("rst_level", 64'(fifo_level), 64'(0));
    rst = 1'b0;
    sb.delete();
    exp_fetch = '0; exp_issue = '0;
    discard_pend = 1'b0; held = 1'b0; have_last = 1'b0;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 3'd0};
    tbl[1]  = '{1'b1, 1'b0, 1'b1, 8'h00, 3'd0};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 8'h00, 3'd1};
    tbl[3]  = '{1'b1, 1'b0, 1'b1, 8'h01, 3'd1};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 8'h00, 3'd2};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 8'h02, 3'd2};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 8'h00, 3'd3};
    tbl[7]  = '{1'b1, 1'b0, 1'b1, 8'h03, 3'd3};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 8'h00, 3'd4};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 8'h00, 3'd4};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 8'h00, 3'd4};
    saw_wrap = 1'b0;
    @(negedge clk);
    do_reset();

    // Fill with ack tied high and the core stalled.
    for (int i = 0; i < 11; i++) begin
      imem_ack    = tbl[i].ack;
      issue_ready = tbl[i].ready;
      check("tbl_req", 64'(imem_req), 64'(tbl[i].req));
      if (tbl[i].req) check("tbl_addr", 64'(imem_addr), 64'(tbl[i].addr));
      check("tbl_level", 64'(fifo_level), 64'(tbl[i].level));
      step();
    end

    // Drain and stream.
    issue_ready = 1'b1;
    for (int i = 0; i < 40; i++) step();

    // PC wrap across 8'hFF.
    redirect_valid = 1'b1; redirect_pc = 8'hFC;
    step();
    redirect_valid = 1'b0;
    for (int i = 0; i < 30; i++) step();
    check("pc_wrap_seen", 64'(saw_wrap), 64'(1));

    // Push and pop together at level 1.
    do_reset();
    imem_ack = 1'b1;
    repeat (3) step();
    issue_ready = 1'b1;
    step();
    check("l1_level", 64'(fifo_level), 64'(1));
    check("l1_pc", 64'(issue_pc), 64'(1));
    issue_ready = 1'b0;

    // Redirect while a request is stalled at address 5.
    do_reset();
    redirect_valid = 1'b1; redirect_pc = 8'h05;
    step();
    redirect_pc = 8'h40;
    check("disc_addr0", 64'(imem_addr), 64'(5));
    step();
    redirect_valid = 1'b0;
    check("disc_addr1", 64'(imem_addr), 64'(5));
    step();
    check("disc_addr2", 64'(imem_addr), 64'(5));
    step();
    imem_ack = 1'b1;
    check("disc_req3", 64'(imem_req), 64'(1));
    check("disc_addr3", 64'(imem_addr), 64'(5));
    step();
    check("disc_idle_req", 64'(imem_req), 64'(0));
    check("disc_dropped", 64'(issue_valid), 64'(0));
    step();
    check("disc_new_addr", 64'(imem_addr), 64'(8'h40));
    step();
    check("disc_first_pc", 64'(issue_pc), 64'(8'h40));
    step();

    // Redirect coincident with transfer and pop at level 2.
    do_reset();
    imem_ack = 1'b1;
    repeat (5) step();
    check("co_level2", 64'(fifo_level), 64'(2));
    check("co_req", 64'(imem_req), 64'(1));
    issue_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 8'h80;
    step();
    issue_ready = 1'b0; redirect_valid = 1'b0;
    check("co_level0", 64'(fifo_level), 64'(0));
    check("co_valid0", 64'(issue_valid), 64'(0));
    step();
    check("co_next_addr", 64'(imem_addr), 64'(8'h80));
    check("co_next_req", 64'(imem_req), 64'(1));
    repeat (3) step();

    // Reset asserted mid-request aborts it.
    imem_ack = 1'b0;
    step();
    check("mid_req_pending", 64'(imem_req), 64'(1));
    rst = 1'b1;
    #1;
    check("mid_rst_req", 64'(imem_req), 64'(0));
    check("mid_rst_level", 64'(fifo_level), 64'(0));
    check("mid_rst_valid", 64'(issue_valid), 64'(0));
    @(negedge clk);
    do_reset();
    imem_ack = 1'b1;
    repeat (6) step();

`ifdef VLIW_FETCH_STALL_CNT_EN
    do_reset();
    imem_ack = 1'b1;
    check("stall_rst", 64'(stall_count), 64'(0));
    repeat (70000) @(negedge clk);
    check("stall_sat", 64'(stall_count), 64'(16'hFFFF));
    repeat (3) @(negedge clk);
    check("stall_nowrap", 64'(stall_count), 64'(16'hFFFF));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vliw_fetch_queue.md
VLIW_FETCH_QUEUE -- requirements
Module: vliw_fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4: bundle FIFO entries, power of two, 2..16.
REQ-002 Parameter AW, default 8: word-address width of instruction memory and PC.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 imem_req  output  1  fetch request, held until accepted.
REQ-006 imem_addr  output  AW  word address of current request.
REQ-007 imem_ack  input  1  memory accepts request and returns data; transfer = imem_req && imem_ack at rising edge.
REQ-008 imem_data  input  32  bundle data, valid in the transfer cycle.
REQ-009 issue_valid  output  1  head bundle available to the VLIW core.
REQ-010 issue_bundle  output  32  head bundle: slot0 op [31:24], slot1 op [23:16], dest0 [15:12], dest1 [11:8].
REQ-011 issue_pc  output  AW  word address of head bundle.
REQ-012 issue_ready  input  1  core consumes head; pop = issue_valid && issue_ready.
REQ-013 redirect_valid  input  1  one-cycle branch/redirect strobe.
REQ-014 redirect_pc  input  AW  new fetch address.
REQ-015 fifo_level  output  $clog2(DEPTH+1)  current number of buffered bundles.

Function
REQ-016 FSM states IDLE, FETCH, DISCARD; imem_req SHALL be 1 exactly in FETCH and DISCARD; imem_addr SHALL be stable while imem_req is 1.
REQ-017 IDLE -> FETCH when fifo_level < DEPTH after this cycle's pop/push; otherwise stay IDLE; at most one request outstanding.
REQ-018 FETCH with transfer and no redirect: push {imem_data, pc} to FIFO, pc <= pc + 1 modulo 2^AW, next state IDLE.
REQ-019 FETCH without transfer, no redirect: stay FETCH.
REQ-020 Redirect in any state: FIFO flushed (level 0), pc <= redirect_pc; redirect overrides same-cycle pop and push.
REQ-021 Redirect in FETCH with no transfer: -> DISCARD; DISCARD keeps old imem_addr, on transfer drops data -> IDLE.
REQ-022 Redirect in FETCH coincident with transfer: data dropped, -> IDLE.
REQ-023 Redirect in DISCARD: pc updated, stay DISCARD unless transfer in the same cycle (-> IDLE).
REQ-024 FIFO first-word-fall-through: a bundle pushed at edge N SHALL drive issue_valid/issue_bundle/issue_pc after edge N.
REQ-025 Simultaneous push and pop SHALL leave fifo_level unchanged, including at level DEPTH-1 and with level 1 (pop of old head, new head visible next cycle).
REQ-026 FIFO SHALL never overflow; pop when empty SHALL be ignored; read/write pointers wrap modulo DEPTH.
REQ-027 issue_valid SHALL be 0 in the cycle after a redirect edge.

Reset
REQ-028 While rst is 1: state IDLE, pc 0, FIFO empty, imem_req 0, issue_valid 0, issue_bundle 0, issue_pc 0, fifo_level 0.
REQ-029 Reset asserted mid-request SHALL abort it; memory side tolerates dropped requests.

Configuration
REQ-030 Macro VLIW_FETCH_STALL_CNT_EN defined: extra output stall_count 16 bits, increments each cycle issue_valid && !issue_ready, saturates at 16'hFFFF, reset to 0, unaffected by redirect.
REQ-031 Macro undefined: port and counter absent; all other behaviour identical.

Structure
REQ-032 Package vliw_pkg SHALL hold bundle field position constants, ALU opcode constants 8'h00..8'h05 (ADD, SUB, AND, OR, XOR, NOT), bundle width 32, and the fetch FSM state enum.
REQ-033 Sub-module vliw_fifo: generic synchronous FWFT FIFO with flush, parameterised width and depth, instantiated once with width 32+AW.

Verification
REQ-034 Reset release, imem_ack tied 1, imem_data = 32'h0001_2300 + addr, issue_ready 0 -> four requests at addr 0..3, fifo_level 4, imem_req then stays 0.
REQ-035 From REQ-034 state, issue_ready 1 -> issue_pc sequence 0,1,2,3,4,... one bundle per two cycles max, no gaps in pc, no duplicates.
REQ-036 AW=8, pc 8'hFF fetched -> next imem_addr 8'h00, issue_pc 8'hFF then 8'h00.
REQ-037 imem_ack held 0 three cycles at addr 5, redirect_valid with redirect_pc 8'h40 in cycle 1 -> imem_addr stays 5 until ack, data discarded, next request addr 8'h40, first issue_pc 8'h40.
REQ-038 Redirect coincident with transfer and pop at level 2 -> fifo_level 0 next cycle, issue_valid 0, next request addr redirect_pc.
REQ-039 VLIW_FETCH_STALL_CNT_EN defined, issue_valid held high with issue_ready 0 for 70000 cycles -> stall_count 16'hFFFF, not wrapping.
